// File: rtl/seg_display_pkg.sv
// Shared glyphs, modes and FSM states for the seven-segment display controller.
// All glyphs are active-low with bit order g..a.
package seg_display_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_e;

    // Double-dabble correction: a BCD digit of 5 or more overflows when doubled.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

endpackage

// File: rtl/seg_hex_encoder.sv
// Combinational nibble-to-glyph encoder, one instance per display digit.
module seg_hex_encoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    // Map each nibble onto its active-low glyph.
    always_comb begin
        case (nibble_i)
            4'h0:    glyph_o = GLYPH_0;
            4'h1:    glyph_o = GLYPH_1;
            4'h2:    glyph_o = GLYPH_2;
            4'h3:    glyph_o = GLYPH_3;
            4'h4:    glyph_o = GLYPH_4;
            4'h5:    glyph_o = GLYPH_5;
            4'h6:    glyph_o = GLYPH_6;
            4'h7:    glyph_o = GLYPH_7;
            4'h8:    glyph_o = GLYPH_8;
            4'h9:    glyph_o = GLYPH_9;
            4'hA:    glyph_o = GLYPH_A;
            4'hB:    glyph_o = GLYPH_B;
            4'hC:    glyph_o = GLYPH_C;
            4'hD:    glyph_o = GLYPH_D;
            4'hE:    glyph_o = GLYPH_E;
            4'hF:    glyph_o = GLYPH_F;
            default: glyph_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: hex writes show immediately, decimal writes run a
// bit-serial double-dabble first. Define SEG_DISPLAY_BLINK_EN to add per-digit blinking.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_mode,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic                    busy,
    output logic                    wr_drop,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int PAD_W = (DATA_W > HEX_W) ? DATA_W : HEX_W;
    localparam int CNT_W = $clog2(DATA_W);

    state_e                  state_q;
    logic                    busy_q;
    logic                    wr_drop_q;
    logic                    overflow_q;
    logic                    shown_q;
    logic [HEX_W-1:0]        disp_q;
    logic [DATA_W-1:0]       src_q;
    logic [HEX_W-1:0]        bcd_q;
    logic [HEX_W-1:0]        bcd_d;
    logic                    conv_ovf_q;
    logic [CNT_W-1:0]        bit_cnt_q;

    logic [PAD_W-1:0]        wr_pad_s;
    logic [HEX_W-1:0]        bcd_adj_s;
    logic                    carry_s;
    logic [7*NUM_DIGITS-1:0] glyph_s;
    logic [7*NUM_DIGITS-1:0] seg_s;
    logic [NUM_DIGITS-1:0]   blink_off_s;

    // Zero-extended so nibbles above DATA_W read as 0.
    assign wr_pad_s = PAD_W'(wr_data);

    // One double-dabble step: add-3 correction on each digit, then shift in the next source bit.
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = bcd_adjust(bcd_q[4*i +: 4]);
        end
        bcd_d   = {bcd_adj_s[HEX_W-2:0], src_q[DATA_W-1]};
        carry_s = bcd_adj_s[HEX_W-1];
    end

    // Write acceptance, decimal conversion FSM and display storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            wr_drop_q  <= 1'b0;
            overflow_q <= 1'b0;
            shown_q    <= 1'b0;
            disp_q     <= '0;
            src_q      <= '0;
            bcd_q      <= '0;
            conv_ovf_q <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            wr_drop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (mode_e'(wr_mode) == MODE_DEC) begin
                            state_q    <= ST_CONVERT;
                            busy_q     <= 1'b1;
                            src_q      <= wr_data;
                            bcd_q      <= '0;
                            conv_ovf_q <= 1'b0;
                            bit_cnt_q  <= '0;
                        end else begin
                            disp_q     <= wr_pad_s[HEX_W-1:0];
                            overflow_q <= 1'b0;
                            shown_q    <= 1'b1;
                        end
                    end
                end
                ST_CONVERT: begin
                    wr_drop_q  <= wr_en;
                    bcd_q      <= bcd_d;
                    src_q      <= {src_q[DATA_W-2:0], 1'b0};
                    conv_ovf_q <= conv_ovf_q | carry_s;
                    bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    // The display only changes once the last source bit is in.
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        disp_q     <= bcd_d;
                        overflow_q <= conv_ovf_q | carry_s;
                        shown_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int BLINK_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_CNT_W-1:0] blink_cnt_q;
    logic                   blink_phase_q;

    // Free-running blink timebase; the phase flips each time the counter wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLINK_CNT_W'(1);
        end
    end

    assign blink_off_s = blink_mask & {NUM_DIGITS{blink_phase_q}};
`else
    assign blink_off_s = '0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg_hex_encoder u_enc (
            .nibble_i (disp_q[4*g +: 4]),
            .glyph_o  (glyph_s[7*g +: 7])
        );
    end

    // Per-digit gating; digit_en must act without waiting for a clock edge.
    always_comb begin
        seg_s = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!digit_en[i] || !shown_q || blink_off_s[i]) begin
                seg_s[7*i +: 7] = SEG_BLANK;
            end else if (overflow_q) begin
                seg_s[7*i +: 7] = SEG_DASH;
            end else begin
                seg_s[7*i +: 7] = glyph_s[7*i +: 7];
            end
        end
    end

    assign seg      = seg_s;
    assign busy     = busy_q;
    assign wr_drop  = wr_drop_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: a driver pushes expected display updates and
// drop pulses into queues; a monitor pops them at their due cycle and compares every cycle.
module tb_seg_display_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_mode = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic        busy;
    logic        wr_drop;
    logic        overflow;
    logic [55:0] seg;

    typedef struct {
        int              due;
        longint unsigned val;
        bit              dec;
    } disp_ev_t;

    disp_ev_t        disp_q[$];
    int              drop_q[$];
    int              cyc = 0;
    int              busy_until = -100;
    int              errors = 0;
    int              checks = 0;

    bit              m_valid = 1'b0;
    longint unsigned m_val = 0;
    bit              m_dec = 1'b0;
    int              busy_run = 0;
    disp_ev_t        ev;
    bit              exp_drop;

    seg_display_ctrl #(
        .NUM_DIGITS (8),
        .DATA_W     (32),
        .BLINK_DIV  (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_mode  (wr_mode),
        .digit_en (digit_en),
`ifdef SEG_DISPLAY_BLINK_EN
        .blink_mask (8'h00),
`endif
        .busy     (busy),
        .wr_drop  (wr_drop),
        .overflow (overflow),
        .seg      (seg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit model_ovf(input bit valid, input longint unsigned v, input bit dec);
        return valid && dec && (v >= 64'd100000000);
    endfunction

    function automatic logic [55:0] model_seg(input bit valid, input longint unsigned v,
                                              input bit dec, input logic [7:0] en);
        logic [55:0]     r;
        longint unsigned p;
        int              d;
        r = '1;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (dec) d = int'((v / p) % 10);
            else     d = int'((v >> (4 * i)) & 64'd15);
            if (en[i] && valid) begin
                r[7*i +: 7] = model_ovf(valid, v, dec) ? 7'b0111111 : glyph(d);
            end
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; the model decides acceptance from its own busy window.
    task automatic drive(input bit en, input longint unsigned v, input bit dec);
        wr_en   = en;
        wr_data = v[31:0];
        wr_mode = dec;
        if (en) begin
            if (cyc > busy_until) begin
                if (dec) begin
                    disp_q.push_back('{due: cyc + 33, val: v, dec: 1'b1});
                    busy_until = cyc + 32;
                end else begin
                    disp_q.push_back('{due: cyc + 1, val: v, dec: 1'b0});
                end
            end else begin
                drop_q.push_back(cyc + 1);
            end
        end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    // Monitor: pop due events, then compare the outputs against the reference model.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                exp_drop = 1'b0;
                if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                    void'(drop_q.pop_front());
                    exp_drop = 1'b1;
                end
                chk("wr_drop", 64'(wr_drop), 64'(exp_drop));
                while (disp_q.size() > 0 && disp_q[0].due == cyc) begin
                    ev = disp_q.pop_front();
                    chk("busy_at_update", 64'(busy), 64'd0);
                    if (ev.dec) chk("busy_cycles", 64'(busy_run), 64'd32);
                    m_valid = 1'b1;
                    m_val   = ev.val;
                    m_dec   = ev.dec;
                end
                chk("seg", 64'(seg), 64'(model_seg(m_valid, m_val, m_dec, digit_en)));
                chk("overflow", 64'(overflow), 64'(model_ovf(m_valid, m_val, m_dec)));
                busy_run = busy ? busy_run + 1 : 0;
            end
        end
    end

    initial begin
        longint unsigned v;
        bit              dec;

        repeat (3) @(negedge clock);
        chk("reset_seg", 64'(seg), 64'({8{7'h7F}}));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop", 64'(wr_drop), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        drive(1'b1, 64'h12345678, 1'b0);
        chk("hex_digit0", 64'(seg[6:0]), 64'(7'b0000000));
        chk("hex_digit7", 64'(seg[55:49]), 64'(7'b1111001));
        chk("hex_busy", 64'(busy), 64'd0);
        idle(2);

        drive(1'b1, 64'd1234, 1'b1);
        idle(35);
        chk("dec1234", 64'(seg), 64'({glyph(0), glyph(0), glyph(0), glyph(0),
                                      glyph(1), glyph(2), glyph(3), glyph(4)}));

        drive(1'b1, 64'd100000000, 1'b1);
        idle(34);
        chk("dec_ovf_flag", 64'(overflow), 64'd1);
        chk("dec_ovf_dash", 64'(seg), 64'({8{7'b0111111}}));
        drive(1'b1, 64'd0, 1'b0);
        idle(2);
        chk("hex0_ovf_clear", 64'(overflow), 64'd0);
        chk("hex0_seg", 64'(seg), 64'({8{7'b1000000}}));

        drive(1'b1, 64'd5, 1'b1);
        idle(2);
        drive(1'b1, 64'd777, 1'b1);
        chk("drop_pulse", 64'(wr_drop), 64'd1);
        idle(1);
        chk("drop_single", 64'(wr_drop), 64'd0);
        idle(40);
        chk("drop_final5", 64'(seg), 64'({{7{7'b1000000}}, 7'b0010010}));

        digit_en = 8'h0F;
        drive(1'b1, 64'hFFFFFFFF, 1'b0);
        chk("digit_en_low", 64'(seg[27:0]), 64'({4{7'b0001110}}));
        chk("digit_en_high", 64'(seg[55:28]), 64'({4{7'h7F}}));
        digit_en = 8'hFF;
        idle(1);

        // Reset in the middle of a conversion must blank at once and drop the result.
        drive(1'b1, 64'd987654, 1'b1);
        idle(9);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_seg", 64'(seg), 64'({8{7'h7F}}));
        disp_q.delete();
        drop_q.delete();
        busy_until = -100;
        m_valid  = 1'b0;
        busy_run = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        drive(1'b1, 64'h0000CAFE, 1'b0);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                dec = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) v = 64'($urandom_range(0, 99999999));
                else                           v = 64'($urandom);
                drive(1'b1, v, dec);
            end else begin
                idle(1);
            end
        end
        digit_en = 8'hFF;
        idle(40);
        chk("scoreboard_drained", 64'(disp_q.size() + drop_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of seven-segment digits driven.
REQ-002 SHALL have parameter DATA_W, default 32: width of the written value. Legal range is 4 to 64.
REQ-003 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per blink phase.
REQ-004 SHALL have the port `clock`, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-005 SHALL have the port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have the port `wr_en`, input, 1 bit: write strobe from the processor.
REQ-007 SHALL have the port `wr_data`, input, DATA_W bits: unsigned value to display.
REQ-008 SHALL have the port `wr_mode`, input, 1 bit: 0 = hex, 1 = unsigned decimal. Sampled together with `wr_en`.
REQ-009 SHALL have the port `digit_en`, input, NUM_DIGITS bits: live per-digit enable. Bit i gates digit i.
REQ-010 SHALL have the port `busy`, output, 1 bit: decimal conversion in progress.
REQ-011 SHALL have the port `wr_drop`, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-012 SHALL have the port `overflow`, output, 1 bit: the last decimal value did not fit in NUM_DIGITS digits.
REQ-013 SHALL have the port `seg`, output, 7*NUM_DIGITS bits. Digit i occupies seg[7i+6:7i], bit order g..a, active-low. Digit 0 is the least significant digit.

Function
REQ-014 SHALL accept a write when `wr_en`=1 and `busy`=0.
REQ-015 SHALL, on a write with `busy`=1, ignore the write, pulse `wr_drop` high for exactly one cycle, and leave the in-flight conversion unaffected.
REQ-016 SHALL, in hex mode, update `seg` on the clock edge after acceptance (latency 1). Digit i shows nibble wr_data[4i+3:4i]; nibbles beyond DATA_W show 0.
REQ-017 SHALL clear `overflow` on every accepted hex write.
REQ-018 SHALL implement decimal mode as sequential double-dabble in two states, IDLE and CONVERT, processing one source bit per cycle.
REQ-019 SHALL hold `busy`=1 for exactly DATA_W cycles, starting the cycle after acceptance.
REQ-020 SHALL load the new `seg` on the same edge that drops `busy`. The digits SHALL then be a decimal-digit conversion of the value (the low NUM_DIGITS decimal digits), with no leading-zero blanking.
REQ-021 SHALL NOT change `seg` during CONVERT; the previous display holds.
REQ-022 SHALL set `overflow`=1 if any carry leaves the top BCD digit during conversion. Only decimal writes raise `overflow`.
REQ-023 SHALL, when `overflow`=1, show a dash (7'b0111111) on every digit.
REQ-024 SHALL drive 7'h7F (blank) on any digit whose `digit_en` bit is 0, combinationally and independent of mode or `busy`.
REQ-025 SHALL be able to accept a write in the same cycle that `busy` falls.

Reset
REQ-026 SHALL, while `reset`=1, immediately force: `seg` all 7'h7F, `busy`=0, `wr_drop`=0, `overflow`=0, stored value 0, state IDLE, blink counter and phase 0.
REQ-027 SHALL abandon any conversion in progress on reset, without updating the display.
REQ-028 SHALL resume in IDLE on the first edge after `reset` deasserts.

Configuration
REQ-029 SHALL, with SEG_DISPLAY_BLINK_EN defined, add the input `blink_mask` [NUM_DIGITS-1:0].
REQ-030 SHALL, with SEG_DISPLAY_BLINK_EN defined, count clock cycles modulo BLINK_DIV and toggle the blink phase at each wrap.
REQ-031 SHALL, with SEG_DISPLAY_BLINK_EN defined, blank a digit with its `blink_mask` bit set while the phase is 1.
REQ-032 SHALL, without SEG_DISPLAY_BLINK_EN, omit the `blink_mask` port and the counter, with no blinking.

Structure
REQ-033 SHALL place in shared package seg_display_pkg:
- the 16 hex glyph constants;
- SEG_BLANK (7'h7F) and SEG_DASH (7'b0111111);
- the mode enum (MODE_HEX, MODE_DEC);
- the FSM state enum.
REQ-034 SHALL use combinational sub-module seg_hex_encoder (4-bit nibble to 7-bit glyph), instantiated NUM_DIGITS times.

Verification (NUM_DIGITS=8, DATA_W=32)
REQ-035 Reset, then hex write 32'h12345678 -> next cycle: digit0 = 7'b0000000 ("8"), digit7 = 7'b1111001 ("1"), `busy`=0.
REQ-036 Decimal write 1234 -> `busy` high for 32 cycles, then digits 0..7 = 4,3,2,1,0,0,0,0 and `overflow`=0.
REQ-037 Decimal write 100000000 -> after 32 cycles `overflow`=1 and all digits 7'b0111111. A following hex write of 0 -> `overflow`=0 and all digits "0".
REQ-038 Decimal write 5, then a write at busy cycle 3 -> `wr_drop` high for one cycle, final display 5, no second conversion.
REQ-039 `digit_en`=8'h0F after hex 32'hFFFFFFFF -> digits 4..7 = 7'h7F, digits 0..3 = "F".
REQ-040 Assert `reset` at conversion cycle 10 -> `busy`=0 and all `seg` 7'h7F with no clock edge.
REQ-041 With SEG_DISPLAY_BLINK_EN, BLINK_DIV=4 and `blink_mask`=8'h01 -> digit0 alternates glyph and blank every 4 cycles.
